commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 40 ++++
 rtl/commit_trace_buffer.sv | 107 ++++++++++
 tb/tb_commit_trace_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: commit trace entry layout and counter widths shared by the trace buffer.
// Store fields exist in the entry only when TRACE_MEM_FIELDS_EN is defined.
package trace_pkg;
    localparam int TRACE_ADDR_W  = 64;
    localparam int TRACE_DATA_W  = 64;
    localparam int TRACE_INSTR_W = 32;
    localparam int TRACE_REG_W   = 5;
    localparam int OVF_CNT_W     = 16;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0]  pc;
        logic [TRACE_INSTR_W-1:0] instr;
        logic                     reg_we;
        logic [TRACE_REG_W-1:0]   rd_addr;
        logic [TRACE_DATA_W-1:0]  rd_data;
`ifdef TRACE_MEM_FIELDS_EN
        logic                     mem_we;
        logic [TRACE_ADDR_W-1:0]  mem_addr;
        logic [TRACE_ADDR_W-1:0]  mem_data;
`endif
    } trace_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-output FIFO with wrapping pointers and occupancy count.
// The caller guarantees no push when full without a pop and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + AW'(1);
            if (i_pop) rd_ptr <= rd_ptr + AW'(1);
            o_count <= o_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_data;
    end

    assign o_valid = o_count != '0;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: queues retired-instruction records for a trace consumer, counts
// retirements and dropped commits, and requests a stall when nearly full (TRACE_MEM_FIELDS_EN adds store fields).
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int ADDR_WIDTH  = TRACE_ADDR_W,
    parameter int DATA_WIDTH  = TRACE_DATA_W,
    parameter int INSTR_WIDTH = TRACE_INSTR_W,
    parameter int REG_ADDR_W  = TRACE_REG_W,
    parameter int DEPTH       = 8,
    parameter int AF_MARGIN   = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_log_trace,
    input  logic [ADDR_WIDTH-1:0]  i_pc_log,
    input  logic [INSTR_WIDTH-1:0] i_instruction_log,
    input  logic                   i_reg_we,
    input  logic [REG_ADDR_W-1:0]  i_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_rd_data,
    input  logic                   i_mem_we_log,
    input  logic [ADDR_WIDTH-1:0]  i_mem_addr_log,
    input  logic [ADDR_WIDTH-1:0]  i_mem_write_data_log,
    input  logic                   i_trace_ready,
    output logic                   o_trace_valid,
    output logic [ADDR_WIDTH-1:0]  o_trace_pc,
    output logic [INSTR_WIDTH-1:0] o_trace_instr,
    output logic                   o_trace_reg_we,
    output logic [REG_ADDR_W-1:0]  o_trace_rd_addr,
    output logic [DATA_WIDTH-1:0]  o_trace_rd_data,
    output logic                   o_trace_mem_we,
    output logic [ADDR_WIDTH-1:0]  o_trace_mem_addr,
    output logic [ADDR_WIDTH-1:0]  o_trace_mem_data,
    output logic [CW-1:0]          o_count,
    output logic                   o_stall_req,
    output logic [OVF_CNT_W-1:0]   o_overflow_cnt,
    output logic [63:0]            o_retired_cnt
);
    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         push;
    logic         pop;
    logic         drop;

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = i_pc_log;
        wr_entry.instr   = i_instruction_log;
        wr_entry.reg_we  = i_reg_we;
        wr_entry.rd_addr = i_rd_addr;
        wr_entry.rd_data = i_rd_data;
`ifdef TRACE_MEM_FIELDS_EN
        wr_entry.mem_we   = i_mem_we_log;
        wr_entry.mem_addr = i_mem_addr_log;
        wr_entry.mem_data = i_mem_write_data_log;
`endif
    end

    // a full buffer still accepts a commit when the head leaves in the same cycle
    assign pop  = o_trace_valid & i_trace_ready;
    assign push = i_log_trace & ((o_count < CW'(DEPTH)) | pop);
    assign drop = i_log_trace & ~push;

    sync_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (wr_entry),
        .o_valid (o_trace_valid),
        .o_data  (rd_entry),
        .o_count (o_count)
    );

    assign o_trace_pc      = rd_entry.pc;
    assign o_trace_instr   = rd_entry.instr;
    assign o_trace_reg_we  = rd_entry.reg_we;
    assign o_trace_rd_addr = rd_entry.rd_addr;
    assign o_trace_rd_data = rd_entry.rd_data;
`ifdef TRACE_MEM_FIELDS_EN
    assign o_trace_mem_we   = rd_entry.mem_we;
    assign o_trace_mem_addr = rd_entry.mem_addr;
    assign o_trace_mem_data = rd_entry.mem_data;
`else
    logic unused_mem;
    assign unused_mem       = ^{i_mem_we_log, i_mem_addr_log, i_mem_write_data_log};
    assign o_trace_mem_we   = 1'b0;
    assign o_trace_mem_addr = '0;
    assign o_trace_mem_data = '0;
`endif

    assign o_stall_req = (CW'(DEPTH) - o_count) <= CW'(AF_MARGIN);

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_overflow_cnt <= '0;
            o_retired_cnt  <= '0;
        end else begin
            if (drop && o_overflow_cnt != '1) o_overflow_cnt <= o_overflow_cnt + OVF_CNT_W'(1);
            if (i_log_trace) o_retired_cnt <= o_retired_cnt + 64'(1);
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scenarios plus random traffic, scored against a queue model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;
    localparam int AFM   = 2;

    logic        clk = 0, arst = 1, log_trace = 0, reg_we = 0, mem_we = 0, ready = 0;
    logic [63:0] pc = 0, rd_data = 0, mem_addr = 0, mem_data = 0;
    logic [31:0] instr = 0;
    logic [4:0]  rd_addr = 0;

    logic        o_valid, o_reg_we, o_mem_we, o_stall;
    logic [63:0] o_pc, o_rd_data, o_mem_addr, o_mem_data, o_ret;
    logic [31:0] o_instr;
    logic [4:0]  o_rd_addr;
    logic [3:0]  o_count;
    logic [15:0] o_ovf;

    commit_trace_buffer dut (
        .i_clk(clk), .i_arst(arst), .i_log_trace(log_trace), .i_pc_log(pc),
        .i_instruction_log(instr), .i_reg_we(reg_we), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
        .i_mem_we_log(mem_we), .i_mem_addr_log(mem_addr), .i_mem_write_data_log(mem_data),
        .i_trace_ready(ready), .o_trace_valid(o_valid), .o_trace_pc(o_pc), .o_trace_instr(o_instr),
        .o_trace_reg_we(o_reg_we), .o_trace_rd_addr(o_rd_addr), .o_trace_rd_data(o_rd_data),
        .o_trace_mem_we(o_mem_we), .o_trace_mem_addr(o_mem_addr), .o_trace_mem_data(o_mem_data),
        .o_count(o_count), .o_stall_req(o_stall), .o_overflow_cnt(o_ovf), .o_retired_cnt(o_ret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        reg_we;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        logic        mem_we;
        logic [63:0] mem_addr;
        logic [63:0] mem_data;
    } ent_t;

    ent_t            exp_q[$];
    int              m_count = 0;
    int              m_ovf = 0;
    longint unsigned m_ret = 0;
    int              checks = 0, failures = 0;
    bit              mon_en = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(logic [63:0] p, logic [31:0] ins);
        ent_t e;
        e = '{pc: p, instr: ins, reg_we: 1'b1, rd_addr: p[6:2], rd_data: ~p,
              mem_we: 1'b0, mem_addr: 64'h0, mem_data: 64'h0};
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e.pc       = {$urandom, $urandom};
        e.instr    = $urandom;
        e.reg_we   = 1'($urandom);
        e.rd_addr  = 5'($urandom);
        e.rd_data  = {$urandom, $urandom};
        e.mem_we   = 1'($urandom);
        e.mem_addr = {$urandom, $urandom};
        e.mem_data = {$urandom, $urandom};
        return e;
    endfunction

    // drive one cycle of inputs, then advance the model past the clock edge
    task automatic step(bit rst, bit lg, bit rdy, ent_t e);
        bit pop, push;
        ent_t x;
        arst = rst; log_trace = lg; ready = rdy;
        pc = e.pc; instr = e.instr; reg_we = e.reg_we; rd_addr = e.rd_addr; rd_data = e.rd_data;
        mem_we = e.mem_we; mem_addr = e.mem_addr; mem_data = e.mem_data;
        pop  = m_count > 0 && rdy;
        push = lg && (m_count < DEPTH || pop);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_count = 0; m_ovf = 0; m_ret = 0;
        end else begin
            if (lg) m_ret++;
            if (lg && !push && m_ovf < 16'hFFFF) m_ovf++;
            if (push) begin
                x = e;
`ifndef TRACE_MEM_FIELDS_EN
                x.mem_we = 1'b0; x.mem_addr = 64'h0; x.mem_data = 64'h0;
`endif
                exp_q.push_back(x);
            end
            m_count += int'(push) - int'(pop);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 64'(o_count), 64'(m_count));
            chk("valid", 64'(o_valid), 64'(m_count > 0));
            chk("stall", 64'(o_stall), 64'((DEPTH - m_count) <= AFM));
            chk("overflow", 64'(o_ovf), 64'(m_ovf));
            chk("retired", o_ret, m_ret);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL head_unexpected actual=valid required=empty");
                end else begin
                    chk("head_pc", o_pc, exp_q[0].pc);
                    chk("head_instr", 64'(o_instr), 64'(exp_q[0].instr));
                    chk("head_reg_we", 64'(o_reg_we), 64'(exp_q[0].reg_we));
                    chk("head_rd_addr", 64'(o_rd_addr), 64'(exp_q[0].rd_addr));
                    chk("head_rd_data", o_rd_data, exp_q[0].rd_data);
                    chk("head_mem_we", 64'(o_mem_we), 64'(exp_q[0].mem_we));
                    chk("head_mem_addr", o_mem_addr, exp_q[0].mem_addr);
                    chk("head_mem_data", o_mem_data, exp_q[0].mem_data);
                    if (ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_pc", o_pc, 64'h0);
                chk("idle_rd_data", o_rd_data, 64'h0);
                chk("idle_mem_addr", o_mem_addr, 64'h0);
            end
        end
    end

    initial begin
        ent_t z, s;
        z = mk(64'h0, 32'h0);
        step(1, 0, 0, z);
        mon_en = 1;
        step(1, 0, 0, z);
        chk("reset_count", 64'(o_count), 64'h0);
        chk("reset_stall", 64'(o_stall), 64'h0);
        // scenario 1: single commit, one-cycle latency, single-cycle valid
        step(0, 0, 1, z);
        step(0, 1, 1, mk(64'h8000_0000, 32'h0000_0013));
        chk("s1_valid", 64'(o_valid), 64'h1);
        chk("s1_pc", o_pc, 64'h8000_0000);
        chk("s1_instr", 64'(o_instr), 64'h13);
        chk("s1_retired", o_ret, 64'h1);
        step(0, 0, 1, z);
        chk("s1_valid_drop", 64'(o_valid), 64'h0);
        // scenario 2: fill with consumer stalled, then overflow
        step(1, 0, 0, z);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, mk(64'h1000 + 64'(i * 4), 32'h13));
            if (i == 4) chk("s2_stall_at5", 64'(o_stall), 64'h0);
            if (i == 5) chk("s2_stall_at6", 64'(o_stall), 64'h1);
        end
        chk("s2_count", 64'(o_count), 64'h8);
        step(0, 1, 0, mk(64'h1100, 32'h13));
        chk("s2_overflow", 64'(o_ovf), 64'h1);
        chk("s2_retired", o_ret, 64'h9);
        chk("s2_head", o_pc, 64'h1000);
        // scenario 3: full with simultaneous push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, mk(64'h2000 + 64'(i * 4), 32'h13));
            chk("s3_count", 64'(o_count), 64'h8);
        end
        chk("s3_overflow", 64'(o_ovf), 64'h1);
        // scenario 4: reset with queued entries and a same-cycle commit
        for (int i = 0; i < 3; i++) step(0, 0, 1, z);
        chk("s4_count5", 64'(o_count), 64'h5);
        step(1, 1, 1, mk(64'h2F00, 32'h13));
        chk("s4_count", 64'(o_count), 64'h0);
        chk("s4_valid", 64'(o_valid), 64'h0);
        chk("s4_ovf", 64'(o_ovf), 64'h0);
        chk("s4_ret", o_ret, 64'h0);
        step(0, 1, 0, mk(64'h3000, 32'h13));
        chk("s4_pc", o_pc, 64'h3000);
        chk("s4_count1", 64'(o_count), 64'h1);
        step(0, 0, 1, z);
        chk("s4_drained", 64'(o_count), 64'h0);
        // scenario 5: store fields
        s = mk(64'h4000, 32'h0000_3023);
        s.mem_we = 1'b1; s.mem_addr = 64'h1000; s.mem_data = 64'hDEAD_BEEF;
        step(0, 1, 0, s);
`ifdef TRACE_MEM_FIELDS_EN
        chk("s5_mem_addr", o_mem_addr, 64'h1000);
        chk("s5_mem_data", o_mem_data, 64'hDEAD_BEEF);
        chk("s5_mem_we", 64'(o_mem_we), 64'h1);
`else
        chk("s5_mem_addr", o_mem_addr, 64'h0);
        chk("s5_mem_data", o_mem_data, 64'h0);
        chk("s5_mem_we", 64'(o_mem_we), 64'h0);
`endif
        step(0, 0, 1, z);
        // scenario 6: overflow counter saturation
        step(1, 0, 0, z);
        for (int i = 0; i < 8; i++) step(0, 1, 0, mk(64'h5000 + 64'(i * 4), 32'h13));
        for (int i = 0; i < 65540; i++) step(0, 1, 0, z);
        chk("s6_ovf_sat", 64'(o_ovf), 64'hFFFF);
        chk("s6_count", 64'(o_count), 64'h8);
        // random traffic with occasional resets
        step(1, 0, 0, z);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd());
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, z);
        chk("final_empty", 64'(o_count), 64'h0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
